pc_fetch_unit: RTL and testbench

Program-counter and instruction-fetch sequencer for the MIPS core. Holds the architectural PC, drives it to the external PC+4 adder and to instruction memory, fetches over a req/ack handshake, and selects the next PC among sequential, branch and jump targets. Detects misaligned targets and memory timeouts and latches a sticky fault.

---
 rtl/pc_fetch_unit.sv | 105 ++++++++++
 tb/tb_pc_fetch_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and req/ack instruction-fetch sequencer
// with next-PC selection and sticky misalignment/timeout fault capture.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] pc_branch,
    input  logic [31:0] pc_jump,
    input  logic [1:0]  pc_src,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic        instr_valid,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, ISSUE, ERR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic [31:0]   fault_addr_q, fault_addr_d;
    logic [1:0]    fault_code_q, fault_code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   next_pc;
    logic          timed_out;

    assign next_pc   = pc_src == 2'b01 ? pc_branch : pc_src == 2'b10 ? pc_jump : pc_plus4;
    assign timed_out = cnt_q == CW'(TIMEOUT - 1);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        cnt_d        = cnt_q;
        fault_code_d = fault_code_q;
        fault_addr_d = fault_addr_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // an ack on the final wait cycle still completes the fetch
                if (imem_ack) begin
                    instr_d = instr_in;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else if (timed_out) begin
                    fault_code_d = 2'b10;
                    fault_addr_d = pc_q;
                    state_d      = ERR;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (next_pc[1:0] != 2'b00) begin
                        fault_code_d = 2'b01;
                        fault_addr_d = next_pc;
                        state_d      = ERR;
                    end else begin
                        pc_d    = next_pc;
                        state_d = REQ;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            cnt_q        <= '0;
            fault_code_q <= 2'b00;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            cnt_q        <= cnt_d;
            fault_code_q <= fault_code_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign imem_req    = state_q == REQ;
    assign instr_valid = state_q == ISSUE;
    assign fault       = state_q == ERR;
    assign instr_out   = instr_q;
    assign fault_code  = fault_code_q;
    assign fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized traffic checked against
// a fetch-transaction reference model of pc_fetch_unit.
module tb_pc_fetch_unit;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc, pc_plus4, pc_branch, pc_jump, imem_addr, instr_in, instr_out, fault_addr;
    logic [1:0]  pc_src, fault_code;
    logic        stall, imem_req, imem_ack, instr_valid, fault;

    int errors = 0;
    int checks = 0;

    // reference model: boot cycle, outstanding fetch, issued instruction, faulted
    bit          m_boot, m_fetching, m_valid, m_faulted;
    int          m_wait;
    logic [31:0] m_pc, m_instr, m_faddr;
    logic [1:0]  m_fcode;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .pc_plus4(pc_plus4), .pc_branch(pc_branch),
        .pc_jump(pc_jump), .pc_src(pc_src), .stall(stall), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_ack(imem_ack), .instr_in(instr_in),
        .instr_out(instr_out), .instr_valid(instr_valid), .fault(fault),
        .fault_code(fault_code), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_boot = 1; m_fetching = 0; m_valid = 0; m_faulted = 0; m_wait = 0;
        m_pc = 32'h0; m_instr = 32'h0; m_faddr = 32'h0; m_fcode = 2'b00;
    endtask

    task automatic model_step();
        logic [31:0] nxt;
        if (!rst_n) model_reset();
        else if (m_boot) begin
            m_boot = 0; m_fetching = 1; m_wait = 0;
        end else if (m_fetching) begin
            m_wait++;
            if (imem_ack) begin
                m_instr = instr_in; m_fetching = 0; m_valid = 1;
            end else if (m_wait == TO) begin
                m_fetching = 0; m_faulted = 1; m_fcode = 2'b10; m_faddr = m_pc;
            end
        end else if (m_valid && !stall) begin
            nxt = pc_src == 2'd1 ? pc_branch : pc_src == 2'd2 ? pc_jump : pc_plus4;
            m_valid = 0;
            if (nxt % 4 != 0) begin
                m_faulted = 1; m_fcode = 2'b01; m_faddr = nxt;
            end else begin
                m_pc = nxt; m_fetching = 1; m_wait = 0;
            end
        end
    endtask

    // the external adder is emulated from the expected PC
    task automatic cyc();
        pc_plus4 = m_pc + 32'd4;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; imem_ack = 0; pc_src = 0;
        pc_branch = 0; pc_jump = 0; instr_in = 0;
        cyc();
        checks++;
        if ({pc, imem_req, instr_valid, instr_out, fault, fault_code, fault_addr} !== {32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_state: got pc=%h req=%b v=%b instr=%h f=%b code=%b addr=%h want all zero", pc, imem_req, instr_valid, instr_out, fault, fault_code, fault_addr);
        end
        rst_n = 1; imem_ack = 1; instr_in = 32'hDEAD_BEEF;
        cyc();
        checks++;
        if ({imem_req, instr_valid, instr_out} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL ack_in_idle: got req=%b v=%b instr=%h want 1 0 00000000", imem_req, instr_valid, instr_out);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] seen[$];
        logic [31:0] word;
        for (int i = 0; i < 7; i++) begin
            imem_ack = m_fetching; word = $urandom; instr_in = word; pc_src = 0;
            cyc();
            checks++;
            if (instr_valid !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL seq_valid_%0d: got %b want %b", i, instr_valid, i % 2 == 0);
            end
            if (instr_valid) begin
                seen.push_back(pc);
                checks++;
                if (instr_out !== word) begin
                    errors++;
                    $display("FAIL seq_instr_%0d: got %h want %h", i, instr_out, word);
                end
            end
        end
        checks++;
        if (seen.size() != 4 || seen[0] !== 32'h0 || seen[1] !== 32'h4 || seen[2] !== 32'h8 || seen[3] !== 32'hC) begin
            errors++;
            $display("FAIL seq_pcs: got %0d pcs first=%h last=%h want 0,4,8,c", seen.size(), seen.size() > 0 ? seen[0] : 32'hx, seen.size() > 0 ? seen[seen.size()-1] : 32'hx);
        end
    endtask

    task automatic test_targets();
        logic [31:0] w;
        imem_ack = 0; pc_src = 2'd1; pc_branch = 32'h40;
        cyc();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
            errors++;
            $display("FAIL branch_target: got req=%b addr=%h want 1 00000040", imem_req, imem_addr);
        end
        w = $urandom; imem_ack = 1; instr_in = w; pc_src = 0;
        cyc();
        imem_ack = 1; instr_in = 32'h1234_5678; pc_src = 2'd2; pc_jump = 32'h100;
        cyc();
        checks++;
        if ({imem_req, imem_addr, instr_out} !== {1'b1, 32'h100, w}) begin
            errors++;
            $display("FAIL jump_target: got req=%b addr=%h instr=%h want 1 00000100 %h", imem_req, imem_addr, instr_out, w);
        end
        instr_in = $urandom;
        cyc();
        imem_ack = 0; pc_src = 2'd3; pc_branch = 32'h200; pc_jump = 32'h300;
        cyc();
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h104}) begin
            errors++;
            $display("FAIL src11_seq: got req=%b addr=%h want 1 00000104", imem_req, imem_addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        imem_ack = 1; instr_in = $urandom; pc_src = 2'd1; pc_branch = 32'h10;
        cyc();
        imem_ack = 0;
        cyc();
        w = $urandom; imem_ack = 1; instr_in = w;
        cyc();
        stall = 1; pc_branch = 32'h43;
        for (int i = 0; i < 3; i++) begin
            instr_in = $urandom;
            cyc();
            checks++;
            if ({pc, instr_valid, instr_out, fault} !== {32'h10, 1'b1, w, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d: got pc=%h v=%b instr=%h f=%b want 00000010 1 %h 0", i, pc, instr_valid, instr_out, fault, w);
            end
        end
        stall = 0; pc_src = 0; imem_ack = 0;
        cyc();
        checks++;
        if ({pc, imem_req} !== {32'h14, 1'b1}) begin
            errors++;
            $display("FAIL stall_release: got pc=%h req=%b want 00000014 1", pc, imem_req);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] w;
        w = $urandom; imem_ack = 1; instr_in = w;
        cyc();
        imem_ack = 0; pc_src = 2'd1; pc_branch = 32'h42;
        cyc();
        checks++;
        if ({fault, fault_code, fault_addr, pc, imem_req, instr_valid} !== {1'b1, 2'b01, 32'h42, 32'h14, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL misaligned: got f=%b code=%b addr=%h pc=%h req=%b v=%b want 1 01 00000042 00000014 0 0", fault, fault_code, fault_addr, pc, imem_req, instr_valid);
        end
        pc_src = 2'd2; pc_jump = 32'h200;
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1; instr_in = $urandom; stall = 1'($urandom);
            cyc();
            checks++;
            if ({fault, fault_code, pc, instr_out, imem_req} !== {1'b1, 2'b01, 32'h14, w, 1'b0}) begin
                errors++;
                $display("FAIL err_frozen_%0d: got f=%b code=%b pc=%h instr=%h req=%b", i, fault, fault_code, pc, instr_out, imem_req);
            end
        end
        stall = 0;
    endtask

    task automatic test_reset_in_err();
        rst_n = 0; imem_ack = 0;
        cyc();
        checks++;
        if ({pc, fault, fault_code, fault_addr, imem_req, instr_out} !== {32'h0, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_in_err: got pc=%h f=%b code=%b addr=%h req=%b instr=%h want all zero", pc, fault, fault_code, fault_addr, imem_req, instr_out);
        end
        rst_n = 1;
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] w;
        imem_ack = 0;
        cyc();
        imem_ack = 1; instr_in = $urandom;
        cyc();
        imem_ack = 0; pc_src = 2'd1; pc_branch = 32'h20;
        cyc();
        n = 0;
        while (imem_req && n < 40) begin
            cyc();
            n++;
        end
        checks++;
        if (n != TO || {fault, fault_code, fault_addr} !== {1'b1, 2'b10, 32'h20}) begin
            errors++;
            $display("FAIL timeout: got %0d req cycles f=%b code=%b addr=%h want %0d 1 10 00000020", n, fault, fault_code, fault_addr, TO);
        end
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
        for (int i = 0; i < TO - 1; i++) cyc();
        checks++;
        if ({imem_req, fault} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_wait: got req=%b f=%b want 1 0", imem_req, fault);
        end
        w = $urandom; imem_ack = 1; instr_in = w;
        cyc();
        checks++;
        if ({instr_valid, fault, instr_out} !== {1'b1, 1'b0, w}) begin
            errors++;
            $display("FAIL ack_at_limit: got v=%b f=%b instr=%h want 1 0 %h", instr_valid, fault, instr_out, w);
        end
    endtask

    task automatic test_reset_mid_req();
        imem_ack = 0; pc_src = 0;
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if ({imem_req, pc} !== {1'b1, 32'h4}) begin
            errors++;
            $display("FAIL pre_reset_req: got req=%b pc=%h want 1 00000004", imem_req, pc);
        end
        rst_n = 0;
        cyc();
        checks++;
        if ({pc, fault, imem_req, instr_valid} !== {32'h0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_req: got pc=%h f=%b req=%b v=%b want 0 0 0 0", pc, fault, imem_req, instr_valid);
        end
        rst_n = 1; imem_ack = 1; instr_in = $urandom;
        cyc();
        cyc();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid_latency: got v=%b want 1", instr_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n = $urandom_range(0, 63) != 0;
            imem_ack = 1'($urandom);
            stall = $urandom_range(0, 3) == 0;
            pc_src = 2'($urandom);
            instr_in = $urandom;
            pc_branch = ($urandom & 32'hFFFF_FFFC) | ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
            pc_jump = ($urandom & 32'hFFFF_FFFC) | ($urandom_range(0, 7) == 0 ? 32'($urandom_range(1, 3)) : 32'h0);
            cyc();
            checks++;
            if ({pc, imem_addr, imem_req, instr_valid, instr_out, fault, fault_code, fault_addr} !== {m_pc, m_pc, m_fetching, m_valid, m_instr, m_faulted, m_fcode, m_faddr}) begin
                errors++;
                $display("FAIL random_%0d: got pc=%h addr=%h req=%b v=%b instr=%h f=%b code=%b faddr=%h want pc=%h req=%b v=%b instr=%h f=%b code=%b faddr=%h",
                         i, pc, imem_addr, imem_req, instr_valid, instr_out, fault, fault_code, fault_addr,
                         m_pc, m_fetching, m_valid, m_instr, m_faulted, m_fcode, m_faddr);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_targets();
        test_stall();
        test_misaligned();
        test_reset_in_err();
        test_timeout();
        test_reset_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
